// File: rtl/bsg_test_node_master_cgol.sv
// Test-node master: issues LFSR-payload request packets one at a time.
// It folds each response into a 64-bit rotating checksum and flags responses carrying the wrong client ID.
module bsg_test_node_master_cgol #(
  parameter int          ring_width_p = 80,
  parameter int          master_id_p  = 0,
  parameter int          client_id_p  = 0,
  parameter int          num_boards_p = 16,
  parameter logic [63:0] seed_p       = 64'h1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  output logic                    v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic                    yumi_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [15:0]             count_o,
  output logic [63:0]             checksum_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_e;

  state_e      state_r, state_n;
  logic [63:0] lfsr_r, lfsr_n;
  logic [15:0] count_r;
  logic [63:0] checksum_r;
  logic        error_r;
  logic [16:0] count_inc;
  logic        send_fire, recv_fire;

  // Only the ID field and payload of a response matter; the remaining bits are intentionally dropped.
  logic unused_data_i;
  assign unused_data_i = ^data_i;

  assign lfsr_n    = (lfsr_r >> 1) ^ (lfsr_r[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  assign count_inc = {1'b0, count_r} + 17'd1;
  assign send_fire = v_o & yumi_i;
  assign recv_fire = v_i & ready_o;

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_n = state_r;
    v_o     = 1'b0;
    ready_o = 1'b0;
    done_o  = 1'b0;
    unique case (state_r)
      IDLE: if (en_i) state_n = SEND;
      SEND: begin
        v_o = en_i;
        if (send_fire) state_n = WAIT;
      end
      WAIT: begin
        ready_o = en_i;
        if (recv_fire)
          state_n = (count_inc < 17'(num_boards_p)) ? SEND : DONE;
      end
      DONE: done_o = 1'b1;
      default: state_n = IDLE;
    endcase
  end

  // The request is a pure function of the held LFSR, so it stays stable while stalled.
  always_comb begin
    data_o        = '0;
    data_o[78:75] = 4'(master_id_p);
    data_o[63:0]  = lfsr_r;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      lfsr_r     <= seed_p;
      count_r    <= '0;
      checksum_r <= '0;
      error_r    <= 1'b0;
    end else begin
      state_r <= state_n;
      if (send_fire) lfsr_r <= lfsr_n;
      if (recv_fire) begin
        count_r    <= count_inc[15:0];
        checksum_r <= {checksum_r[62:0], checksum_r[63]} ^ data_i[63:0];
        if (data_i[78:75] != 4'(client_id_p)) error_r <= 1'b1;
      end
    end
  end

  assign count_o    = count_r;
  assign checksum_o = checksum_r;
  assign error_o    = error_r;

endmodule

// File: tb/tb_bsg_test_node_master_cgol.sv
// Directed bench for bsg_test_node_master_cgol with num_boards_p=3, master ID 5 and client ID 0.
// Expected values are computed by hand from the LFSR and checksum rules.
module tb_bsg_test_node_master_cgol;

  localparam int W = 80;

  logic         clk = 1'b0;
  logic         reset_i, en_i, yumi_i, v_i;
  logic [W-1:0] data_i;
  logic         v_o, ready_o, done_o, error_o;
  logic [W-1:0] data_o;
  logic [15:0]  count_o;
  logic [63:0]  checksum_o;

  int checks = 0;
  int errors = 0;

  bsg_test_node_master_cgol #(
    .ring_width_p(W), .master_id_p(5), .client_id_p(0),
    .num_boards_p(3), .seed_p(64'h1)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .done_o(done_o), .error_o(error_o),
    .count_o(count_o), .checksum_o(checksum_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] resp(input logic [3:0] id, input logic [63:0] payload);
    logic [W-1:0] p;
    p = '0;
    p[78:75] = id;
    p[63:0]  = payload;
    return p;
  endfunction

  initial begin
    reset_i = 1'b1; en_i = 1'b0; yumi_i = 1'b0; v_i = 1'b0; data_i = '0;
    tick(); tick();
    reset_i = 1'b0; en_i = 1'b1;

    // First cycle after reset: idle, everything zero.
    check("rst_v", 64'(v_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_checksum", checksum_o, 64'd0);

    tick();
    check("send1_v", 64'(v_o), 64'd1);
    check("send1_payload", data_o[63:0], 64'h1);
    check("send1_id", 64'(data_o[78:75]), 64'h5);
    check("send1_pad", 64'({data_o[79], data_o[74:64]}), 64'd0);

    // Stall: no yumi, request must hold.
    tick();
    check("stall_v", 64'(v_o), 64'd1);
    check("stall_payload", data_o[63:0], 64'h1);

    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    check("wait1_v", 64'(v_o), 64'd0);
    check("wait1_ready", 64'(ready_o), 64'd1);

    // yumi while v_o=0 must not advance the LFSR.
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    check("wait1_yumi_ign", 64'(ready_o), 64'd1);

    // en_i=0 in WAIT with a pending response: nothing accepted.
    en_i = 1'b0; v_i = 1'b1; data_i = resp(4'h0, 64'h1);
    #1;
    check("frozen_ready", 64'(ready_o), 64'd0);
    tick();
    check("frozen_count", 64'(count_o), 64'd0);
    en_i = 1'b1;
    #1;
    check("resume_ready", 64'(ready_o), 64'd1);
    tick(); v_i = 1'b0;
    check("resp1_count", 64'(count_o), 64'd1);
    check("resp1_checksum", checksum_o, 64'h1);
    check("send2_v", 64'(v_o), 64'd1);
    check("send2_payload", data_o[63:0], 64'hD800_0000_0000_0000);

    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    // Response with a bad ID: still counted and folded.
    v_i = 1'b1; data_i = resp(4'hF, 64'h2);
    tick(); v_i = 1'b0;
    check("resp2_count", 64'(count_o), 64'd2);
    check("resp2_checksum", checksum_o, 64'h0);
    check("resp2_error", 64'(error_o), 64'd1);
    check("send3_payload", data_o[63:0], 64'h6C00_0000_0000_0000);

    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    v_i = 1'b1; data_i = resp(4'h0, 64'h4);
    tick();
    check("done_rise", 64'(done_o), 64'd1);
    check("done_count", 64'(count_o), 64'd3);
    check("done_checksum", checksum_o, 64'h4);
    check("done_v", 64'(v_o), 64'd0);
    check("error_sticky", 64'(error_o), 64'd1);

    // DONE ignores further handshakes.
    yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold_v", 64'(v_o), 64'd0);
      check("done_hold_ready", 64'(ready_o), 64'd0);
      check("done_hold_count", 64'(count_o), 64'd3);
    end
    yumi_i = 1'b0; v_i = 1'b0;

    // Reset while in WAIT with a response presented at the same edge.
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    check("rst2_done", 64'(done_o), 64'd0);
    check("rst2_error", 64'(error_o), 64'd0);
    tick();
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    check("wait4_ready", 64'(ready_o), 64'd1);
    reset_i = 1'b1; v_i = 1'b1; data_i = resp(4'h0, 64'h7);
    tick();
    reset_i = 1'b0;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_checksum", checksum_o, 64'd0);
    check("midrst_ready", 64'(ready_o), 64'd0);
    tick(); v_i = 1'b0;
    check("midrst_count2", 64'(count_o), 64'd0);
    check("midrst_v", 64'(v_o), 64'd1);
    check("midrst_seed", data_o[63:0], 64'h1);

    // en_i=0 in SEND forces v_o low and holds the request.
    en_i = 1'b0; yumi_i = 1'b1; tick();
    check("send_frozen_v", 64'(v_o), 64'd0);
    en_i = 1'b1; yumi_i = 1'b0;
    #1;
    check("send_resume_payload", data_o[63:0], 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_test_node_master_cgol.md
BSG_TEST_NODE_MASTER_CGOL -- requirements
Module: bsg_test_node_master_cgol

Interface
REQ-001 The block SHALL have parameter ring_width_p, default 80, meaning ring packet width; legal values are >= 79.
REQ-002 The block SHALL have parameter master_id_p, default 0, meaning the 4-bit ID of this master node.
REQ-003 The block SHALL have parameter client_id_p, default 0, meaning the 4-bit ID of the target client node.
REQ-004 The block SHALL have parameter num_boards_p, default 16, meaning the number of boards per run; legal range is 1..65535.
REQ-005 The block SHALL have parameter seed_p, default 64'h1, meaning the nonzero LFSR seed.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset_i, input, 1 bit: synchronous active-high reset.
REQ-008 The block SHALL have port en_i, input, 1 bit: run enable.
REQ-009 The block SHALL have port v_o, input/output as follows: output, 1 bit, request packet valid.
REQ-010 The block SHALL have port data_o, output, ring_width_p bits: request packet.
REQ-011 The block SHALL have port yumi_i, input, 1 bit: downstream consumed data_o.
REQ-012 The block SHALL have port v_i, input, 1 bit: response packet valid.
REQ-013 The block SHALL have port data_i, input, ring_width_p bits: response packet.
REQ-014 The block SHALL have port ready_o, output, 1 bit: able to accept a response.
REQ-015 The block SHALL have port done_o, output, 1 bit: run complete.
REQ-016 The block SHALL have port error_o, output, 1 bit: sticky response-ID mismatch.
REQ-017 The block SHALL have port count_o, output, 16 bits: responses received.
REQ-018 The block SHALL have port checksum_o, output, 64 bits: running checksum of response payloads.

Function
REQ-019 The request packet format SHALL be: bits [78:75] = 4'(master_id_p), bits [74:64] = 0, bits [63:0] = the current LFSR value, and all bits above 78 = 0.
REQ-020 The LFSR SHALL be a 64-bit Galois right-shift register: next = (x>>1) ^ (x[0] ? 64'hD800000000000000 : 0).
REQ-021 The LFSR SHALL advance only on the cycle v_o & yumi_i.
REQ-022 The FSM SHALL have the states IDLE, SEND, WAIT and DONE.
REQ-023 IDLE SHALL transition to SEND on the next edge when en_i=1.
REQ-024 SEND SHALL drive v_o = en_i and SHALL transition to WAIT on v_o & yumi_i.
REQ-025 WAIT SHALL drive ready_o = en_i and SHALL accept a response on v_i & ready_o.
REQ-026 On an accepted response in WAIT, the FSM SHALL go to SEND if count+1 < num_boards_p, else to DONE.
REQ-027 DONE SHALL hold done_o=1, v_o=0, and ready_o=0 until reset.
REQ-028 In every state other than SEND, v_o SHALL be 0; in every state other than WAIT, ready_o SHALL be 0.
REQ-029 yumi_i while v_o=0 SHALL be ignored, and v_i while ready_o=0 SHALL be ignored with no state change.
REQ-030 At most one request SHALL be outstanding at any time.
REQ-031 data_o SHALL remain stable while v_o=1 and yumi_i=0.
REQ-032 On each accepted response: count_o += 1, and checksum_o = {checksum_o[62:0], checksum_o[63]} ^ data_i[63:0], both updated at the next edge (1-cycle latency).
REQ-033 On each accepted response, if data_i[78:75] != client_id_p, error_o SHALL set to 1 at the next edge and stay set until reset; the response SHALL still be counted and folded.
REQ-034 en_i=0 SHALL freeze all state, the LFSR and the outputs (other than v_o/ready_o forced to 0); the run SHALL resume where it left off when en_i returns to 1.

Reset
REQ-035 While reset_i=1 at a clock edge, the block SHALL set state=IDLE, LFSR=seed_p, count_o=0, checksum_o=0, error_o=0, done_o=0, v_o=0, and ready_o=0.
REQ-036 Reset asserted mid-operation (SEND or WAIT) SHALL abandon any outstanding request and restart from seed_p, with no further response accepted for the old request.

Verification
REQ-037 Reset test: after reset with en_i=1, all outputs SHALL be 0 in the first cycle, and v_o=1 in the second cycle with data_o[63:0]=64'h1 and data_o[78:75]=master_id_p.
REQ-038 LFSR test: seed_p=1, yumi first request -> the second request payload SHALL be 64'hD800000000000000.
REQ-039 Checksum test: responses with payload 64'h1 then 64'h2 -> checksum_o SHALL be 64'h1 and then 64'h0; count_o SHALL be 1 and then 2.
REQ-040 Completion test: num_boards_p=3 with an echoing client -> done_o SHALL rise the cycle after the 3rd accept, count_o=3, and v_o SHALL stay 0 thereafter.
REQ-041 ID mismatch test: a response with data_i[78:75]=4'hF when client_id_p=0 -> error_o SHALL be 1 from the next cycle, remain 1, and count_o SHALL still increment.
REQ-042 Stall test: en_i=0 in WAIT with v_i=1 -> ready_o SHALL be 0 and count_o unchanged; reset asserted during WAIT -> IDLE, count_o=0, and data_o[63:0] SHALL return to seed_p.
